// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared op/state encodings and default width for the mul/div unit
package mul_div_unit_pkg;

  localparam int MDU_DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7
  } alu_op_e;

  // Bit 2 marks the divide group; within it bit 1 selects remainder and bit 0 unsigned.
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e o);
    return o[2];
  endfunction

  function automatic logic op_a_signed(input mdu_op_e o);
    return (o == OP_MULH) || (o == OP_MULHSU) || (o == OP_DIV) || (o == OP_REM);
  endfunction

  function automatic logic op_b_signed(input mdu_op_e o);
    return (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// rtl/mdu_divider.sv - restoring divider on magnitudes, one quotient bit per step
module mdu_divider #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] quo_next_o,
  output logic [W-1:0] rem_next_o
);

  logic [W-1:0] quo_q, rem_q, dvsr_q;
  logic [W:0]   rem_sh, trial;

  // Partial remainder stays below the divisor, so one extra bit catches the borrow.
  always_comb begin
    rem_sh = {rem_q, quo_q[W-1]};
    trial  = rem_sh - {1'b0, dvsr_q};
    if (trial[W]) begin
      rem_next_o = rem_sh[W-1:0];
      quo_next_o = {quo_q[W-2:0], 1'b0};
    end else begin
      rem_next_o = trial[W-1:0];
      quo_next_o = {quo_q[W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
    end else if (load_i) begin
      quo_q  <= dividend_i;
      rem_q  <= '0;
      dvsr_q <= divisor_i;
    end else if (step_i) begin
      quo_q  <= quo_next_o;
      rem_q  <= rem_next_o;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide unit; divider built only when MDU_DIV_EN is defined
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = MDU_DATA_WIDTH,
  parameter int OP_BITS    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_BITS-1:0]    op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  err,
  output logic                  busy
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  mdu_state_e   state_q;
  mdu_op_e      op_q;
  logic         neg_q, err_q;
  logic [W-1:0] mcand_q, q_q;
  logic [2*W-1:0] acc_q;
  logic [CW-1:0]  cnt_q;

  mdu_op_e      op_in;
  logic         op_known, is_rem, a_neg, b_neg, neg_d, accept;
  logic         spec_d, spec_err_d;
  logic [W-1:0] a_mag, b_mag, spec_q_d, result;
  logic [W:0]   mul_sum;
  logic [2*W-1:0] mul_next, prod_fix;
  logic [W-1:0] mul_res;

  assign op_in    = mdu_op_e'(op[2:0]);
  assign op_known = ((op >> 3) == '0);
  assign is_rem   = op_is_div(op_in) & op_in[1];
  assign a_neg    = op_a_signed(op_in) & a[W-1];
  assign b_neg    = op_b_signed(op_in) & b[W-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign neg_d    = a_neg ^ (b_neg & ~is_rem);
  assign accept   = (state_q == ST_IDLE) & in_valid;

  always_comb begin
    spec_d     = 1'b0;
    spec_err_d = 1'b0;
    spec_q_d   = '0;
    if (!op_known) begin
      spec_d     = 1'b1;
      spec_err_d = 1'b1;
    end else if (op_is_div(op_in)) begin
`ifdef MDU_DIV_EN
      if (b == '0) begin
        spec_d   = 1'b1;
        spec_q_d = is_rem ? a : '1;
      end else if (!op_in[0] && a == MIN_VAL && b == '1) begin
        spec_d   = 1'b1;
        spec_q_d = is_rem ? '0 : MIN_VAL;
      end
`else
      spec_d     = 1'b1;
      spec_err_d = 1'b1;
`endif
    end
  end

  // Product register starts as {0, multiplier}; each step adds the multiplicand and shifts right.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, acc_q[W-1:1]};
    prod_fix = neg_q ? -mul_next : mul_next;
    mul_res  = (op_q == OP_MUL) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
  end

`ifdef MDU_DIV_EN
  logic [W-1:0] div_quo, div_rem, div_mag;

  mdu_divider #(.W(W)) u_divider (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .step_i     (state_q == ST_CALC),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quo_next_o (div_quo),
    .rem_next_o (div_rem)
  );

  assign div_mag = op_q[1] ? div_rem : div_quo;
  assign result  = op_q[2] ? (neg_q ? -div_mag : div_mag) : mul_res;
`else
  assign result  = mul_res;
`endif

  // The last CALC edge both takes the final step and applies sign correction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q    <= op_in;
            neg_q   <= neg_d;
            mcand_q <= a_mag;
            acc_q   <= {{W{1'b0}}, b_mag};
            cnt_q   <= '0;
            q_q     <= spec_q_d;
            err_q   <= spec_err_d;
            state_q <= spec_d ? ST_DONE : ST_CALC;
          end
        end
        ST_CALC: begin
          acc_q <= mul_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(W-1)) begin
            q_q     <= result;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign q         = q_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - randomized bench for mul_div_unit against an arithmetic reference model
module tb_mul_div_unit;

  localparam int W = 32;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [2:0]   op_in = 3'd0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         in_ready, out_valid, err, busy;
  logic [W-1:0] q;

  mul_div_unit #(.DATA_WIDTH(W), .OP_BITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op_in),
    .a         (a_in),
    .b         (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: full-width integer arithmetic on 64-bit values.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] rq, output logic re, output int lat);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    rq = '0;
    re = 1'b0;
    lat = W + 1;
    p = 0;
    case (o)
      3'd0: begin p = ua * ub; rq = p[31:0]; end
      3'd1: begin p = sa * sb; rq = p[63:32]; end
      3'd2: begin p = sa * ub; rq = p[63:32]; end
      3'd3: begin p = ua * ub; rq = p[63:32]; end
      default: begin
        if (!DIV_EN) begin
          re = 1'b1;
          lat = 1;
        end else if (b == '0) begin
          rq = o[1] ? a : '1;
          lat = 1;
        end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          rq = o[1] ? 32'h0 : 32'h8000_0000;
          lat = 1;
        end else begin
          case (o)
            3'd4:    p = sa / sb;
            3'd5:    p = ua / ub;
            3'd6:    p = sa % sb;
            default: p = ua % ub;
          endcase
          rq = p[31:0];
        end
      end
    endcase
  endfunction

  bit prev_rst = 1'b0, prev2_rst = 1'b0, ov_prev = 1'b0, hs_pending = 1'b0;
  int wait_cnt = 0;

  initial begin : compare
    exp_t         e;
    logic [W-1:0] mq;
    logic         me;
    int           ml;

    model(3'd0, 32'd7, 32'hFFFF_FFFD, mq, me, ml);
    chk("pin_mul_q", 64'(mq), 64'hFFFF_FFEB);
    chk("pin_mul_lat", 64'(ml), 64'd33);
    model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mq, me, ml);
    chk("pin_mulhu_q", 64'(mq), 64'hFFFF_FFFE);
    model(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mq, me, ml);
    chk("pin_mulhsu_q", 64'(mq), 64'hFFFF_FFFF);
`ifdef MDU_DIV_EN
    model(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, mq, me, ml);
    chk("pin_div_ovf_q", 64'(mq), 64'h8000_0000);
    chk("pin_div_ovf_lat", 64'(ml), 64'd1);
    model(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, mq, me, ml);
    chk("pin_rem_ovf_q", 64'(mq), 64'd0);
    model(3'd5, 32'd100, 32'd0, mq, me, ml);
    chk("pin_divu_zero_q", 64'(mq), 64'hFFFF_FFFF);
    model(3'd7, 32'd100, 32'd0, mq, me, ml);
    chk("pin_remu_zero_q", 64'(mq), 64'd100);
    model(3'd4, 32'hFFFF_FFF9, 32'd2, mq, me, ml);
    chk("pin_div_neg_q", 64'(mq), 64'hFFFF_FFFD);
    model(3'd6, 32'hFFFF_FFF9, 32'd2, mq, me, ml);
    chk("pin_rem_neg_q", 64'(mq), 64'hFFFF_FFFF);
`else
    model(3'd5, 32'd100, 32'd7, mq, me, ml);
    chk("pin_divu_err", 64'(me), 64'd1);
    chk("pin_divu_errq", 64'(mq), 64'd0);
    chk("pin_divu_errlat", 64'(ml), 64'd1);
`endif

    forever begin
      @(negedge clk);
      if (prev_rst) begin
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_q", 64'(q), 64'd0);
      end else begin
        if (prev2_rst) chk("in_ready_after_rst", 64'(in_ready), 64'd1);
        if (hs_pending) begin
          chk("hs_out_valid_drop", 64'(out_valid), 64'd0);
          chk("hs_idle_in_ready", 64'(in_ready), 64'd1);
          hs_pending = 1'b0;
        end
        if (out_valid) begin
          wait_cnt = 0;
          if (expq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL spurious_out_valid: got 1, expected 0 (cycle %0d)", cyc);
          end else begin
            e = expq[0];
            chk("q", 64'(q), 64'(e.q));
            chk("err", 64'(err), 64'(e.err));
            chk("in_ready_done", 64'(in_ready), 64'd0);
            if (!ov_prev) chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
            if (out_ready) begin
              void'(expq.pop_front());
              hs_pending = 1'b1;
            end
          end
        end else if (expq.size() != 0) begin
          chk("in_ready_calc", 64'(in_ready), 64'd0);
          chk("busy_calc", 64'(busy), 64'd1);
          wait_cnt++;
          if (wait_cnt == 60) begin
            n_cmp++;
            n_fail++;
            $display("FAIL result_timeout: got no out_valid, expected one within %0d cycles", W + 1);
            expq.delete();
            wait_cnt = 0;
          end
        end
      end
      ov_prev = out_valid;
      if (rst) begin
        expq.delete();
        hs_pending = 1'b0;
        wait_cnt = 0;
        ov_prev = 1'b0;
      end else if (in_valid && in_ready) begin
        model(op_in, a_in, b_in, mq, me, ml);
        e = '{q: mq, err: me, lat: ml, acc: cyc + 1};
        expq.push_back(e);
      end
      prev2_rst = prev_rst;
      prev_rst = rst;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 100) begin
      tick();
      t++;
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit poke);
    int t = 0;
    wait_ready();
    in_valid = 1'b1;
    op_in = o;
    a_in = a;
    b_in = b;
    tick();
    in_valid = 1'b0;
    op_in = 3'($urandom);
    a_in = $urandom;
    b_in = $urandom;
    while (!out_valid && t < 60) begin
      tick();
      t++;
    end
    if (poke) in_valid = 1'b1;
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin : driver
    repeat (3) tick();
    rst = 1'b0;
    tick();

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(3'd5, 32'd100, 32'd0, 0, 1'b0);
    run_op(3'd7, 32'd100, 32'd0, 0, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op(3'd5, 32'd1000, 32'd7, 0, 1'b0);
    run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5, 1'b1);

    wait_ready();
    in_valid = 1'b1;
    op_in = 3'd1;
    a_in = $urandom;
    b_in = $urandom;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (45) tick();

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
